// File: rtl/pict_ram_loader_if.sv
// rtl/pict_ram_loader_if.sv - byte-stream input and picture-RAM write port bundle for pict_ram_loader
interface pict_ram_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [11:0]           wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, byte_data, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, byte_data, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/pict_ram_loader.sv
// rtl/pict_ram_loader.sv - packs byte pairs into 12-bit pixels and writes them to picture RAM
// Optional trailing checksum byte verification enabled by PICT_RAM_LOADER_CHECKSUM_EN.
module pict_ram_loader #(
  parameter int PIXEL_COUNT = 4096,
  parameter int ADDR_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  pict_ram_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, CHECK, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(PIXEL_COUNT - 1);

  state_t                state, state_nxt;
  logic                  byte_ready, busy, done;
  logic                  accept, start_acc, last_pix;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [3:0]            red;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [11:0]           wr_data;
  logic                  error;

  assign accept    = bus.byte_valid && byte_ready;
  assign start_acc = (state == IDLE) && bus.start;
  assign last_pix  = (pix_cnt == LAST_PIX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = LOAD_HI;
      end
      LOAD_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_nxt = LOAD_LO;
      end
      LOAD_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) begin
`ifdef PICT_RAM_LOADER_CHECKSUM_EN
          state_nxt = last_pix ? CHECK : LOAD_HI;
`else
          state_nxt = last_pix ? DONE : LOAD_HI;
`endif
        end
      end
      CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter advances during the write cycle but saturates on the last pixel so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
      red     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_acc)
        pix_cnt <= '0;
      else if (wr_en && !last_pix)
        pix_cnt <= pix_cnt + 1'b1;
      if (accept && state == LOAD_HI)
        red <= bus.byte_data[3:0];
      if (accept && state == LOAD_LO) begin
        wr_en   <= 1'b1;
        wr_addr <= pix_cnt;
        wr_data <= {red, bus.byte_data};
      end
    end
  end

`ifdef PICT_RAM_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum   <= '0;
      error <= 1'b0;
    end else if (start_acc) begin
      sum   <= '0;
      error <= 1'b0;
    end else if (accept && (state == LOAD_HI || state == LOAD_LO)) begin
      sum <= sum + bus.byte_data;
    end else if (accept && state == CHECK) begin
      error <= (bus.byte_data != sum);
    end
  end
`else
  assign error = 1'b0;
`endif

  assign bus.byte_ready = byte_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr;
  assign bus.wr_data    = wr_data;
  assign bus.error      = error;
endmodule

// File: tb/tb_pict_ram_loader.sv
// tb/tb_pict_ram_loader.sv - directed scoreboard bench for pict_ram_loader
module tb_pict_ram_loader;
  typedef struct packed {
    logic [15:0] addr;
    logic [11:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic done_wr  = 1'b0;
  wr_t  exp_q[$];

  logic [7:0] pic_a[8] = '{8'h0F, 8'hA5, 8'h01, 8'h23, 8'h02, 8'h34, 8'h03, 8'h45};
  logic [7:0] pic_b[8] = '{8'hF7, 8'h9C, 8'h5A, 8'hBC, 8'h00, 8'h00, 8'hFF, 8'hFF};

  always #5 clk = ~clk;

  pict_ram_loader_if #(.ADDR_WIDTH(16)) bus ();

  pict_ram_loader #(.PIXEL_COUNT(4), .ADDR_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef PICT_RAM_LOADER_CHECKSUM_EN
  pict_ram_loader_if #(.ADDR_WIDTH(16)) bus2 ();

  pict_ram_loader #(.PIXEL_COUNT(2), .ADDR_WIDTH(16)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.wr_en === 1'b1) begin
      chk("wr_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_wr = bus.wr_en;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      step();
    end
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("byte_accept_timeout", 32'(bus.byte_ready), 32'd1);
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic load_pic(input logic [7:0] b[8], input bit gap, input bit pulse_start);
    logic [7:0] sum = 8'h00;
    wr_t e;
    done_cnt  = 0;
    done_wr   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      e.addr = 16'(i);
      e.data = {b[2*i][3:0], b[2*i+1]};
      exp_q.push_back(e);
      if (pulse_start && i == 1) bus.start = 1'b1;
      send_byte(b[2*i], gap);
      bus.start = 1'b0;
      send_byte(b[2*i+1], gap);
      sum = sum + b[2*i] + b[2*i+1];
    end
`ifdef PICT_RAM_LOADER_CHECKSUM_EN
    send_byte(sum, gap);
    chk("done_with_last_write", 32'(done_wr), 32'd0);
`else
    chk("done_with_last_write", 32'(done_wr), 32'd1);
`endif
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    chk("error_after_load", 32'(bus.error), 32'd0);
    if (pulse_start) bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ready", 32'(bus.byte_ready), 32'd0);
    step();
    chk("no_restart_busy", 32'(bus.busy), 32'd0);
    chk("single_done", 32'(done_cnt), 32'd1);
  endtask

`ifdef PICT_RAM_LOADER_CHECKSUM_EN
  task automatic chk_load(input logic [7:0] cs, input logic exp_err);
    logic [7:0] b[4] = '{8'h01, 8'h10, 8'h02, 8'h20};
    bus2.start = 1'b1;
    step();
    bus2.start      = 1'b0;
    bus2.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus2.byte_data = b[i];
      step();
    end
    bus2.byte_data = cs;
    step();
    bus2.byte_valid = 1'b0;
    chk("cs_done", 32'(bus2.done), 32'd1);
    chk("cs_error", 32'(bus2.error), 32'(exp_err));
  endtask
`endif

  initial begin
    bus.start      = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
`ifdef PICT_RAM_LOADER_CHECKSUM_EN
    bus2.start      = 1'b0;
    bus2.byte_data  = 8'h00;
    bus2.byte_valid = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    rst = 1'b1;

    bus.byte_data  = 8'h55;
    bus.byte_valid = 1'b1;
    step();
    chk("idle_no_consume", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b0;

    load_pic(pic_a, 1'b0, 1'b0);
    load_pic(pic_a, 1'b1, 1'b0);
    load_pic(pic_a, 1'b0, 1'b1);
    load_pic(pic_b, 1'b0, 1'b0);

    // Abort just after the second pixel write.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: 16'(i), data: {pic_a[2*i][3:0], pic_a[2*i+1]}});
      send_byte(pic_a[2*i], 1'b0);
      send_byte(pic_a[2*i+1], 1'b0);
    end
    chk("abort_writes_seen", 32'(exp_q.size()), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_wr_en", 32'(bus.wr_en), 32'd0);
    chk("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("abort_wr_data", 32'(bus.wr_data), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_data  = 8'h12;
    bus.byte_valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    chk("post_reset_idle", 32'(bus.busy), 32'd0);
    bus.byte_valid = 1'b0;
    load_pic(pic_a, 1'b0, 1'b0);

`ifdef PICT_RAM_LOADER_CHECKSUM_EN
    chk_load(8'h33, 1'b0);
    chk_load(8'h34, 1'b1);
    step();
    step();
    chk("cs_error_held", 32'(bus2.error), 32'd1);
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    chk("cs_error_cleared", 32'(bus2.error), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
